hsv_pipe_ctrl: RTL and testbench

- Flow controller for the 8-stage RGB→HSV datapath (stages s1..s8, one register per stage).
- Accepts a pixel stream with a valid/ready handshake and drives a single global stage-enable `pipe_en` into the datapath.
- Carries valid, start-of-frame and end-of-frame flags alongside the pixel, aligned with it at every stage.
- Applies downstream backpressure by stalling the whole pipeline, and sequences frame drain and completion.
- Sits between the pixel source (camera/DMA) and the HSV consumer (threshold/mask logic).
- Control only: RGB/HSV data buses connect source→datapath→sink directly.

---
 rtl/hsv_pkg.sv | 24 ++
 rtl/hsv_sb_delay.sv | 33 +++
 rtl/hsv_pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_hsv_pipe_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared types and constants for the RGB->HSV flow controller.
// Contents:
//   HSV_LATENCY - number of registered datapath stages (s1..s8)
//   HSV_CNT_W   - default width of the in-flight and per-frame counters
//   state_t     - controller FSM states
//   sb_t        - per-stage sideband flags carried alongside each pixel
package hsv_pkg;

    localparam int unsigned HSV_LATENCY = 8;
    localparam int unsigned HSV_CNT_W   = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eof;
    } sb_t;

endpackage

// File: rtl/hsv_sb_delay.sv
// Sideband delay line: LATENCY-deep shift register of sb_t with a common enable,
// matching the stage registers of the HSV datapath one for one.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, clears every stage
//   en    - shift enable (the global pipe_en)
//   d     - sideband entering stage 0
//   q     - sideband leaving stage LATENCY-1
module hsv_sb_delay
    import hsv_pkg::*;
#(
    parameter int unsigned LATENCY = HSV_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  sb_t  d,
    output sb_t  q
);

    sb_t [LATENCY-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= {sr_q[LATENCY-2:0], d};
        end
    end

    assign q = sr_q[LATENCY-1];

endmodule

// File: rtl/hsv_pipe_ctrl.sv
// Flow controller for the 8-stage RGB->HSV datapath. Drives a single global
// stage enable, carries valid/sof/eof alongside the pixel, stalls the whole
// pipe on downstream backpressure and sequences frame drain / completion.
// Optional build macro: HSV_CTRL_PERF_EN adds stall_cnt and pix_cnt outputs.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - source handshake; in_sof/in_eof frame markers
//   pipe_en              - datapath stage enable
//   out_valid/out_ready  - sink handshake; out_sof/out_eof aligned markers
//   busy                 - controller not idle
//   frame_done           - one-cycle pulse after an eof pixel leaves
//   frame_pix            - pixel count of the last completed frame
//   stall_cnt, pix_cnt   - (HSV_CTRL_PERF_EN only) stall cycles, output pixels
module hsv_pipe_ctrl
    import hsv_pkg::*;
#(
    parameter int unsigned LATENCY = HSV_LATENCY,
    parameter int unsigned CNT_W   = HSV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             pipe_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_pix
`ifdef HSV_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      pix_cnt
`endif
);

    state_t           state_q, state_d;
    sb_t              sb_in, sb_out;
    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc;
    logic [CNT_W-1:0] frame_pix_q, frame_pix_d;
    logic             frame_done_q, frame_done_d;

    // Stall only when the last stage holds a pixel the sink refuses.
    assign pipe_en  = !(sb_out.vld && !out_ready);
    assign in_ready = pipe_en && (state_q != DRAIN);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = sb_out.vld && out_ready;

    always_comb begin
        sb_in     = '0;
        sb_in.vld = in_xfer;
        sb_in.sof = in_sof & in_xfer;
        sb_in.eof = in_eof & in_xfer;
    end

    hsv_sb_delay #(
        .LATENCY(LATENCY)
    ) u_sb_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pipe_en),
        .d    (sb_in),
        .q    (sb_out)
    );

    assign out_valid  = sb_out.vld;
    assign out_sof    = sb_out.sof;
    assign out_eof    = sb_out.eof;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_pix  = frame_pix_q;

    always_comb begin
        inflight_d = inflight_q;
        case ({in_xfer, out_xfer})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) state_d = in_eof ? DRAIN : RUN;
            end
            RUN: begin
                if (in_xfer && in_eof) state_d = DRAIN;
            end
            DRAIN: begin
                // Any pixels still behind the departing eof keep us in RUN.
                if (out_xfer && sb_out.eof) begin
                    state_d = (inflight_d == '0) ? IDLE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A sof pixel restarts the count at 1, so a sof+eof pixel reports 1.
    assign fcnt_inc = sb_out.sof ? CNT_W'(1) : fcnt_q + CNT_W'(1);

    always_comb begin
        fcnt_d       = fcnt_q;
        frame_pix_d  = frame_pix_q;
        frame_done_d = 1'b0;
        if (out_xfer) begin
            if (sb_out.eof) begin
                frame_pix_d  = fcnt_inc;
                fcnt_d       = '0;
                frame_done_d = 1'b1;
            end else begin
                fcnt_d = fcnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            inflight_q   <= '0;
            fcnt_q       <= '0;
            frame_pix_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            fcnt_q       <= fcnt_d;
            frame_pix_q  <= frame_pix_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef HSV_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, pix_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            pix_cnt_q   <= '0;
        end else begin
            if (!pipe_en) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (out_xfer) pix_cnt_q <= pix_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign pix_cnt   = pix_cnt_q;
`endif

endmodule

// File: tb/tb_hsv_pipe_ctrl.sv
module tb_hsv_pipe_ctrl;
    import hsv_pkg::*;

    localparam int LAT = 8;
    localparam int CW  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b1;
    logic          in_ready, pipe_en, out_valid, out_sof, out_eof, busy, frame_done;
    logic [CW-1:0] frame_pix;
`ifdef HSV_CTRL_PERF_EN
    logic [31:0]   stall_cnt, pix_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hsv_pipe_ctrl #(
        .LATENCY(LAT),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .pipe_en   (pipe_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_pix (frame_pix)
`ifdef HSV_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .pix_cnt   (pix_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of in-flight pixels, each aged by the number of
    // enabled clock edges since acceptance; the head is visible at the output
    // once it has aged LAT edges.
    typedef struct {
        bit sof;
        bit eof;
        int age;
    } pix_t;

    pix_t mq[$];
    bit   m_busy, m_drain, m_done;
    int   m_fcnt, m_fpix;
    int   m_stall, m_pix;

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].age == LAT);
    endfunction

    function automatic bit m_pipe_en();
        return !(m_out_valid() && !out_ready);
    endfunction

    function automatic bit m_in_ready();
        return m_pipe_en() && !m_drain;
    endfunction

    task automatic model_step();
        bit   ov, pe, ixf, oxf;
        pix_t h, n;
        ov  = m_out_valid();
        pe  = m_pipe_en();
        ixf = in_valid && m_in_ready();
        oxf = ov && out_ready;
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_drain = 0; m_done = 0;
            m_fcnt = 0; m_fpix = 0; m_stall = 0; m_pix = 0;
            return;
        end
        m_done = 0;
        if (!pe) m_stall++;
        if (oxf) begin
            h = mq.pop_front();
            m_pix++;
            if (h.eof) begin
                m_fpix = h.sof ? 1 : m_fcnt + 1;
                m_fcnt = 0;
                m_done = 1;
                if (m_drain) begin
                    m_drain = 0;
                    m_busy  = (mq.size() > 0) || ixf;
                end
            end else begin
                m_fcnt = h.sof ? 1 : m_fcnt + 1;
            end
        end
        if (pe) foreach (mq[i]) mq[i].age++;
        if (ixf) begin
            n.sof = in_sof; n.eof = in_eof; n.age = 1;
            mq.push_back(n);
            m_busy = 1;
            if (in_eof) m_drain = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_sof = 0; in_eof = 0; out_ready = 1;
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL rst_out_sof: got %b want 0", out_sof); end
        checks++; if (out_eof !== 1'b0) begin errors++; $display("FAIL rst_out_eof: got %b want 0", out_eof); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        checks++; if (frame_pix !== '0) begin errors++; $display("FAIL rst_frame_pix: got %0d want 0", frame_pix); end
        checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL rst_pipe_en: got %b want 1", pipe_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_frame();
        int first_v = -1, n_v = 0, sof_c = -1, eof_c = -1, done_c = -1;
        int pix_at12 = -1;
        bit busy_at12 = 1'b1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 4); in_sof = (c == 0); in_eof = (c == 3); out_ready = 1;
            #1;
            if (out_valid) begin n_v++; if (first_v < 0) first_v = c; end
            if (out_sof && sof_c < 0) sof_c = c;
            if (out_eof && eof_c < 0) eof_c = c;
            if (frame_done && done_c < 0) done_c = c;
            if (c == 12) begin pix_at12 = int'(frame_pix); busy_at12 = busy; end
            cycle();
        end
        checks++; if (first_v !== 8) begin errors++; $display("FAIL sf_first_valid: got %0d want 8", first_v); end
        checks++; if (n_v !== 4) begin errors++; $display("FAIL sf_valid_count: got %0d want 4", n_v); end
        checks++; if (sof_c !== 8) begin errors++; $display("FAIL sf_sof_cycle: got %0d want 8", sof_c); end
        checks++; if (eof_c !== 11) begin errors++; $display("FAIL sf_eof_cycle: got %0d want 11", eof_c); end
        checks++; if (done_c !== 12) begin errors++; $display("FAIL sf_done_cycle: got %0d want 12", done_c); end
        checks++; if (pix_at12 !== 4) begin errors++; $display("FAIL sf_frame_pix: got %0d want 4", pix_at12); end
        checks++; if (busy_at12 !== 1'b0) begin errors++; $display("FAIL sf_busy12: got %b want 0", busy_at12); end
    endtask

    task automatic test_backpressure();
        int sent = 0, outs = 0, stall_pe = 0, stall_ir = 0, maxinf = 0, sofs = 0, eofs = 0;
        do_reset();
        for (int c = 0; c < 45; c++) begin
            in_valid = (sent < 20); in_sof = (sent == 0); in_eof = (sent == 19);
            out_ready = !(c >= 10 && c < 15);
            #1;
            if (c >= 10 && c < 15) begin
                if (!pipe_en) stall_pe++;
                if (!in_ready) stall_ir++;
            end
            if (out_valid && out_ready) begin
                outs++;
                if (out_sof) sofs++;
                if (out_eof) eofs++;
            end
            if (int'(dut.inflight_q) > maxinf) maxinf = int'(dut.inflight_q);
            if (in_valid && in_ready) sent++;
            cycle();
        end
        checks++; if (stall_pe !== 5) begin errors++; $display("FAIL bp_pipe_en_low: got %0d want 5", stall_pe); end
        checks++; if (stall_ir !== 5) begin errors++; $display("FAIL bp_in_ready_low: got %0d want 5", stall_ir); end
        checks++; if (outs !== 20) begin errors++; $display("FAIL bp_out_count: got %0d want 20", outs); end
        checks++; if (sofs !== 1 || eofs !== 1) begin errors++; $display("FAIL bp_markers: got sof %0d eof %0d want 1 1", sofs, eofs); end
        checks++; if (frame_pix !== CW'(20)) begin errors++; $display("FAIL bp_frame_pix: got %0d want 20", frame_pix); end
        checks++; if (maxinf > LAT) begin errors++; $display("FAIL bp_inflight_max: got %0d want <=%0d", maxinf, LAT); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, ir_low = 0, n_done = 0, bad_pix = 0, sof1 = -1, sof2 = -1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 6); in_sof = (sent % 3 == 0); in_eof = (sent % 3 == 2); out_ready = 1;
            #1;
            if (c >= 3 && c <= 10 && !in_ready) ir_low++;
            if (out_valid && out_sof) begin
                if (sof1 < 0) sof1 = c; else if (sof2 < 0) sof2 = c;
            end
            if (frame_done) begin n_done++; if (frame_pix !== CW'(3)) bad_pix++; end
            if (in_valid && in_ready) sent++;
            cycle();
        end
        checks++; if (ir_low !== 8) begin errors++; $display("FAIL b2b_in_ready_drain: got %0d want 8", ir_low); end
        checks++; if (sof1 !== 8 || sof2 !== 19) begin errors++; $display("FAIL b2b_sof_cycles: got %0d,%0d want 8,19", sof1, sof2); end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        checks++; if (bad_pix !== 0) begin errors++; $display("FAIL b2b_frame_pix: got %0d bad want 0", bad_pix); end
    endtask

    task automatic test_single_pixel();
        int n_v = 0, done_c = -1;
        bit busy1 = 0, ir1 = 1, busy9 = 1;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            in_valid = (c == 0); in_sof = (c == 0); in_eof = (c == 0); out_ready = 1;
            #1;
            if (c == 1) begin busy1 = busy; ir1 = in_ready; end
            if (c == 9) busy9 = busy;
            if (out_valid) n_v++;
            if (frame_done && done_c < 0) done_c = c;
            cycle();
        end
        checks++; if (busy1 !== 1'b1 || ir1 !== 1'b0) begin errors++; $display("FAIL sp_drain: got busy %b in_ready %b want 1 0", busy1, ir1); end
        checks++; if (n_v !== 1) begin errors++; $display("FAIL sp_valid_count: got %0d want 1", n_v); end
        checks++; if (done_c !== 9) begin errors++; $display("FAIL sp_done_cycle: got %0d want 9", done_c); end
        checks++; if (frame_pix !== CW'(1)) begin errors++; $display("FAIL sp_frame_pix: got %0d want 1", frame_pix); end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL sp_idle: got %b want 0", busy9); end
    endtask

    task automatic test_reset_midframe();
        int late_v = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; in_sof = (c == 0); in_eof = 0; out_ready = 1;
            cycle();
        end
        in_valid = 0; in_sof = 0;
        rst_n = 0;
        cycle();
        rst_n = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_idle: got %b want 0", busy); end
        checks++; if (dut.inflight_q !== '0) begin errors++; $display("FAIL mr_inflight: got %0d want 0", dut.inflight_q); end
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (out_valid) late_v++;
        end
        checks++; if (late_v !== 0) begin errors++; $display("FAIL mr_ghost_valid: got %0d want 0", late_v); end
    endtask

    task automatic test_random();
        int pos = 0, len = 1;
        do_reset();
        len = $urandom_range(6, 1);
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) < 75);
            in_sof    = (pos == 0);
            in_eof    = (pos == len - 1);
            #1;
            checks++;
            if (out_valid !== m_out_valid() || out_sof !== (m_out_valid() && mq[0].sof) ||
                out_eof !== (m_out_valid() && mq[0].eof)) begin
                errors++;
                $display("FAIL rnd_out c%0d: got v%b s%b e%b want v%b", c, out_valid, out_sof,
                         out_eof, m_out_valid());
            end
            checks++;
            if (pipe_en !== m_pipe_en() || in_ready !== m_in_ready()) begin
                errors++;
                $display("FAIL rnd_flow c%0d: got pe%b ir%b want pe%b ir%b", c, pipe_en, in_ready,
                         m_pipe_en(), m_in_ready());
            end
            checks++;
            if (busy !== m_busy || frame_done !== m_done || frame_pix !== CW'(m_fpix)) begin
                errors++;
                $display("FAIL rnd_frame c%0d: got b%b d%b p%0d want b%b d%b p%0d", c, busy,
                         frame_done, frame_pix, m_busy, m_done, m_fpix);
            end
            if (in_valid && m_in_ready()) begin
                pos++;
                if (pos == len) begin pos = 0; len = $urandom_range(6, 1); end
            end
            cycle();
        end
    endtask

`ifdef HSV_CTRL_PERF_EN
    task automatic test_perf();
        int sent = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 10); in_sof = (sent == 0); in_eof = (sent == 9);
            out_ready = !(c >= 9 && c < 12);
            #1;
            if (in_valid && in_ready) sent++;
            cycle();
        end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", stall_cnt); end
        checks++; if (pix_cnt !== 32'd10) begin errors++; $display("FAIL perf_pix: got %0d want 10", pix_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_single_pixel();
        test_reset_midframe();
        test_random();
`ifdef HSV_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
